lr_sigmoid_classifier: RTL and testbench

Pipelined hypothesis stage for the line-buffer logistic-regression datapath. Takes the raw inner-product sum `hprime` (signed Q16.16) from the inner-product stage and applies a piecewise-linear (PLAN) sigmoid to get a probability. It thresholds that probability into a class label and keeps running totals of samples and positive decisions. Valid/ready handshakes on both sides let it sit between the combinational inner-product stage and the result sink/UART framer.

---
 rtl/lr_sigmoid_classifier_if.sv | 24 ++
 rtl/lr_sigmoid_classifier.sv | 112 +++++++++++
 tb/tb_lr_sigmoid_classifier.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lr_sigmoid_classifier_if.sv
// Handshake bundle for the sigmoid hypothesis stage: the sample input side
// (in_valid/in_ready/hprime) and the result output side
// (out_valid/out_ready/prob/label).
interface lr_sigmoid_classifier_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] hprime;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] prob;
  logic        label;

  // Producer/consumer view (test driver, upstream and downstream glue)
  modport master (
    output in_valid, hprime, out_ready,
    input  in_ready, out_valid, prob, label
  );

  // The classifier itself
  modport slave (
    input  in_valid, hprime, out_ready,
    output in_ready, out_valid, prob, label
  );
endinterface

// File: rtl/lr_sigmoid_classifier.sv
// Three-stage hypothesis pipeline: |hprime| -> PLAN sigmoid segment ->
// symmetry + threshold. One global enable moves every stage together,
// so a stalled output freezes the whole pipe and back-pressure reaches
// in_ready combinationally. Delivered samples and positive decisions are
// tallied in wrapping counters.
module lr_sigmoid_classifier #(
  parameter int          FRAC   = 16,
  parameter logic [16:0] THRESH = 17'h08000,
  parameter int          CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  lr_sigmoid_classifier_if.slave bus,
  input  logic                   clear_cnt,
  output logic [CNT_W-1:0]       cnt_total,
  output logic [CNT_W-1:0]       cnt_pos
);

  // 1.0 in the Q1.16 output format
  localparam logic [16:0] ONE = 17'(1 << FRAC);

  logic             adv;
  logic             v1_reg, v2_reg, v3_reg;
  logic             s1_reg, s2_reg;
  logic [31:0]      a1_reg;
  logic [16:0]      y2_reg;
  logic [16:0]      prob_reg;
  logic             label_reg;
  logic [31:0]      a_next;
  logic [16:0]      y_next;
  logic [16:0]      prob_next;
  logic             label_next;
  logic [CNT_W-1:0] cnt_total_reg, cnt_pos_reg;

  // The pipe moves whenever the output slot is empty or being consumed
  assign adv          = !v3_reg | bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out_valid = v3_reg;
  assign bus.prob      = prob_reg;
  assign bus.label     = label_reg;
  assign cnt_total     = cnt_total_reg;
  assign cnt_pos       = cnt_pos_reg;

  // S1 input: magnitude of hprime; -2^31 has no positive twin, so clamp it
  always_comb begin
    a_next = bus.hprime;
    if (bus.hprime[31]) begin
      a_next = (bus.hprime == 32'h8000_0000) ? 32'h7FFF_FFFF
                                             : (~bus.hprime + 32'd1);
    end
  end

  // S2 input: PLAN segment select; boundary points fall in the upper segment.
  // Below 5.0 the magnitude fits in 19 bits, so the shifted slices below
  // carry every significant bit of the truncated shift.
  always_comb begin
    y_next = ONE;
    if (a1_reg >= 32'h0005_0000) begin
      y_next = ONE;
    end else if (a1_reg >= 32'h0002_6000) begin
      y_next = a1_reg[21:5] + 17'h0D800;
    end else if (a1_reg >= 32'h0001_0000) begin
      y_next = a1_reg[19:3] + 17'h0A000;
    end else begin
      y_next = a1_reg[18:2] + 17'h08000;
    end
  end

  // S3 input: mirror negative inputs about 0.5 and take the decision
  always_comb begin
    prob_next  = s2_reg ? (ONE - y2_reg) : y2_reg;
    label_next = (prob_next >= THRESH);
  end

  // Pipeline registers: all stages advance together or all hold
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      v3_reg    <= 1'b0;
      s1_reg    <= 1'b0;
      s2_reg    <= 1'b0;
      a1_reg    <= '0;
      y2_reg    <= '0;
      prob_reg  <= '0;
      label_reg <= 1'b0;
    end else if (adv) begin
      v1_reg    <= bus.in_valid;
      s1_reg    <= bus.hprime[31];
      a1_reg    <= a_next;
      v2_reg    <= v1_reg;
      s2_reg    <= s1_reg;
      y2_reg    <= y_next;
      v3_reg    <= v2_reg;
      prob_reg  <= prob_next;
      label_reg <= label_next;
    end
  end

  // Delivery counters; a clear wins over a same-cycle delivery
  always_ff @(posedge clk) begin
    if (rst || clear_cnt) begin
      cnt_total_reg <= '0;
      cnt_pos_reg   <= '0;
    end else if (v3_reg && bus.out_ready) begin
      cnt_total_reg <= cnt_total_reg + 1'b1;
      cnt_pos_reg   <= cnt_pos_reg + CNT_W'(label_reg);
    end
  end

endmodule

// File: tb/tb_lr_sigmoid_classifier.sv
// Self-checking bench for lr_sigmoid_classifier: a scoreboard of expected
// results (from a plain-arithmetic sigmoid model) checked on every delivery,
// plus literal reference points, back-pressure, boundaries, counter wrap and
// clear, and reset in the middle of a stall.
module tb_lr_sigmoid_classifier;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear_cnt = 1'b0;
  logic [CNT_W-1:0] cnt_total, cnt_pos;

  lr_sigmoid_classifier_if bus ();

  lr_sigmoid_classifier #(
    .FRAC  (16),
    .THRESH(17'h08000),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .clear_cnt(clear_cnt),
    .cnt_total(cnt_total),
    .cnt_pos  (cnt_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          prob;
    bit          label;
    int          cyc;
    logic [31:0] h;
  } exp_t;

  exp_t        exp_q[$];
  int          got_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cycle = 0;
  bit          lat_check = 1'b0;
  bit          bp_mode = 1'b0;
  int          mtot = 0;
  int          mpos = 0;
  bit          rst_seen = 1'b0;
  bit          prev_stall = 1'b0;
  logic [16:0] prev_prob;
  logic        prev_label;

  // Sigmoid from the segment table, using real division instead of shifts
  function automatic int model_prob(input logic [31:0] h);
    longint v, a;
    int     y;
    v = longint'($signed(h));
    a = (v < 0) ? -v : v;
    if (a > 64'h7FFF_FFFF) a = 64'h7FFF_FFFF;
    if (a >= 'h50000)      y = 65536;
    else if (a >= 'h26000) y = int'(a / 32) + 'hD800;
    else if (a >= 'h10000) y = int'(a / 8) + 'hA000;
    else                   y = int'(a / 4) + 'h8000;
    return (v < 0) ? 65536 - y : y;
  endfunction

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard / compare process, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (rst) begin
      exp_q.delete();
      mtot       = 0;
      mpos       = 0;
      rst_seen   = 1'b1;
      prev_stall = 1'b0;
    end else begin
      if (rst_seen) begin
        check(bus.out_valid == 1'b0, "rst_out_valid", bus.out_valid, 0);
        check(bus.prob == 17'h0, "rst_prob", bus.prob, 0);
        check(bus.label == 1'b0, "rst_label", bus.label, 0);
        check(cnt_total == '0, "rst_cnt_total", cnt_total, 0);
        check(cnt_pos == '0, "rst_cnt_pos", cnt_pos, 0);
        check(bus.in_ready == 1'b1, "rst_in_ready", bus.in_ready, 1);
        rst_seen = 1'b0;
      end
      if (prev_stall) begin
        check(bus.out_valid && bus.prob == prev_prob && bus.label == prev_label,
              "stall_hold", bus.prob, prev_prob);
      end
      check(bus.in_ready == (!bus.out_valid || bus.out_ready), "in_ready",
            bus.in_ready, (!bus.out_valid || bus.out_ready));
      check(int'(cnt_total) == mtot, "cnt_total", cnt_total, mtot);
      check(int'(cnt_pos) == mpos, "cnt_pos", cnt_pos, mpos);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "spurious_output", bus.prob, 0);
        end else begin
          e = exp_q.pop_front();
          $display("tx cyc=%0d hprime=%08h prob=%05h label=%0d", cycle, e.h, bus.prob, bus.label);
          check(int'(bus.prob) == e.prob, "prob", bus.prob, e.prob);
          check(bus.label == e.label, "label", bus.label, e.label);
          if (lat_check) check(cycle == e.cyc + 3, "latency", cycle - e.cyc, 3);
          got_q.push_back(int'(bus.prob));
          mtot = (mtot + 1) % (1 << CNT_W);
          mpos = (mpos + (bus.label ? 1 : 0)) % (1 << CNT_W);
        end
      end
      if (clear_cnt) begin
        mtot = 0;
        mpos = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        e.h     = bus.hprime;
        e.prob  = model_prob(bus.hprime);
        e.label = (e.prob >= 'h8000);
        e.cyc   = cycle;
        exp_q.push_back(e);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_prob  = bus.prob;
      prev_label = bus.label;
    end
  end

  // Pseudo-random back-pressure
  always @(posedge clk) begin
    #1;
    if (bp_mode) bus.out_ready = 1'($urandom % 2);
  end

  task automatic send(input logic [31:0] h);
    bit acc;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.hprime   = h;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check(1'b0, "accept_timeout", n, 200);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(exp_q.size() == 0, "drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear_cnt = 1'b1;
    @(posedge clk);
    #1;
    clear_cnt = 1'b0;
  endtask

  initial begin
    logic [31:0] ref_h [6];
    int          ref_p [6];
    bit          ref_l [6];
    logic [31:0] seg_a [6];
    int          seg_p [6];
    logic [31:0] h;
    int          exp_pos;

    ref_h = '{32'h0, 32'h10000, 32'hFFFF0000, 32'h26000, 32'h60000, 32'h80000000};
    ref_p = '{'h08000, 'h0C000, 'h04000, 'h0EB00, 'h10000, 'h00000};
    ref_l = '{1, 1, 0, 1, 1, 0};
    seg_a = '{32'h0FFFF, 32'h10000, 32'h25FFF, 32'h26000, 32'h4FFFF, 32'h50000};
    seg_p = '{'h0BFFF, 'h0C000, 'h0EBFF, 'h0EB00, 'h0FFFF, 'h10000};

    bus.in_valid  = 1'b0;
    bus.hprime    = '0;
    bus.out_ready = 1'b1;

    // Reset, with a sample offered during reset that must be ignored
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.hprime   = 32'h50000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reference points
    lat_check = 1'b1;
    got_q.delete();
    foreach (ref_h[i]) begin
      check(model_prob(ref_h[i]) == ref_p[i], "model_ref", model_prob(ref_h[i]), ref_p[i]);
      check((model_prob(ref_h[i]) >= 'h8000) == ref_l[i], "model_ref_label",
            (model_prob(ref_h[i]) >= 'h8000), ref_l[i]);
      send(ref_h[i]);
    end
    drain();
    check(got_q.size() == 6, "ref_count", got_q.size(), 6);
    foreach (ref_p[i]) if (i < got_q.size()) check(got_q[i] == ref_p[i], "ref_prob", got_q[i], ref_p[i]);

    // Back-pressure
    pulse_clear();
    lat_check = 1'b0;
    got_q.delete();
    exp_pos = 0;
    bp_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      h = $urandom % 32'h60000;
      if ($urandom % 2) h = ~h + 32'd1;
      if (model_prob(h) >= 'h8000) exp_pos++;
      send(h);
    end
    drain();
    bp_mode = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check(got_q.size() == 8, "bp_delivered", got_q.size(), 8);
    check(cnt_total == 4'd8, "bp_cnt_total", cnt_total, 8);
    check(int'(cnt_pos) == exp_pos, "bp_cnt_pos", cnt_pos, exp_pos);

    // Segment boundaries, both signs
    lat_check = 1'b1;
    got_q.delete();
    foreach (seg_a[i]) begin
      check(model_prob(seg_a[i]) == seg_p[i], "model_seg", model_prob(seg_a[i]), seg_p[i]);
      send(seg_a[i]);
      send(~seg_a[i] + 32'd1);
    end
    drain();
    check(got_q.size() == 12, "seg_count", got_q.size(), 12);
    foreach (seg_p[i]) begin
      if (2 * i + 1 < got_q.size()) begin
        check(got_q[2*i] == seg_p[i], "seg_prob", got_q[2*i], seg_p[i]);
        check(got_q[2*i] + got_q[2*i+1] == 'h10000, "seg_symmetry",
              got_q[2*i] + got_q[2*i+1], 'h10000);
      end
    end

    // Counter wrap with CNT_W=4: 17 positives leave 1/1
    pulse_clear();
    for (int i = 0; i < 17; i++) send(32'h10000);
    drain();
    check(cnt_total == 4'd1, "wrap_cnt_total", cnt_total, 1);
    check(cnt_pos == 4'd1, "wrap_cnt_pos", cnt_pos, 1);

    // Clear in the same cycle as a delivery
    send(32'h10000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check(bus.out_valid == 1'b1, "clr_align", bus.out_valid, 1);
    clear_cnt = 1'b1;
    @(posedge clk);
    #1;
    clear_cnt = 1'b0;
    check(cnt_total == 4'd0, "clr_cnt_total", cnt_total, 0);
    check(cnt_pos == 4'd0, "clr_cnt_pos", cnt_pos, 0);
    drain();

    // Reset with three samples in flight and the output stalled
    send(32'h0);
    drain();
    check(cnt_total == 4'd1, "pre_rst_cnt", cnt_total, 1);
    lat_check = 1'b0;
    bus.out_ready = 1'b0;
    send(32'h10000);
    send(32'hFFFF0000);
    send(32'h26000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check(bus.out_valid == 1'b0, "midrst_out_valid", bus.out_valid, 0);
    check(cnt_total == 4'd0, "midrst_cnt_total", cnt_total, 0);
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    lat_check = 1'b1;
    got_q.delete();
    send(32'h0);
    drain();
    check(got_q.size() == 1, "post_rst_count", got_q.size(), 1);
    if (got_q.size() > 0) check(got_q[0] == 'h08000, "post_rst_prob", got_q[0], 'h08000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
